// File: rtl/rrf_recovery_ctrl.sv
// RRF -> RAT recovery sequencer: stall rename, let the last commit land, bulk-copy the
// committed map, rebuild the free list. Optional counters under RRF_RECOVERY_STATS_EN.
module rrf_recovery_ctrl #(
  parameter  int P_REG_NUM    = 64,
  parameter  int ARCH_REG_NUM = 32,
  parameter  int COPY_WIDTH   = 4,
  localparam int PTAG_W       = $clog2(P_REG_NUM),
  localparam int AIDX_W       = $clog2(ARCH_REG_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_req,
  input  logic                           regf_we,
  input  logic [ARCH_REG_NUM*PTAG_W-1:0] restore_rat,
  output logic                           rename_stall,
  output logic                           rat_wr_en,
  output logic [AIDX_W-1:0]              rat_wr_base,
  output logic [COPY_WIDTH*PTAG_W-1:0]   rat_wr_tag,
  output logic                           fl_restore,
  output logic                           recovery_done,
  output logic                           busy
`ifdef RRF_RECOVERY_STATS_EN
  ,
  output logic [15:0]                    flush_count,
  output logic [31:0]                    stall_cycles
`endif
);

  // state       | meaning
  // IDLE        | normal operation, waiting for a flush
  // WAIT_COMMIT | rename frozen, letting the in-flight RRF write settle
  // COPY        | writing COPY_WIDTH RAT entries per cycle from the RRF
  // FL_RESET    | one-cycle free-list rebuild pulse
  // DONE        | one-cycle completion pulse; rename resumes next cycle

  localparam int COPY_CYCLES = ARCH_REG_NUM / COPY_WIDTH;
  localparam int CNT_W       = (COPY_CYCLES > 1) ? $clog2(COPY_CYCLES) : 1;
  localparam int GRP_W       = COPY_WIDTH * PTAG_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COPY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_COMMIT = 3'd1,
    COPY        = 3'd2,
    FL_RESET    = 3'd3,
    DONE        = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // flush_req outside IDLE and regf_we outside WAIT_COMMIT are deliberately ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = WAIT_COMMIT;
          cnt_nxt   = '0;
        end
      end
      WAIT_COMMIT: begin
        if (!regf_we) begin
          state_nxt = COPY;
          cnt_nxt   = '0;
        end
      end
      COPY: begin
        if (cnt == CNT_LAST) begin
          state_nxt = FL_RESET;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FL_RESET: state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    rename_stall  = (state != IDLE);
    rat_wr_en     = (state == COPY);
    fl_restore    = (state == FL_RESET);
    recovery_done = (state == DONE);
    rat_wr_base   = '0;
    rat_wr_tag    = '0;
    if (state == COPY) begin
      rat_wr_base = AIDX_W'(cnt) * AIDX_W'(COPY_WIDTH);
      for (int g = 0; g < COPY_CYCLES; g++) begin
        if (cnt == CNT_W'(g)) rat_wr_tag = restore_rat[g*GRP_W +: GRP_W];
      end
    end
  end

`ifdef RRF_RECOVERY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == IDLE && flush_req && flush_count != '1)
        flush_count <= flush_count + 1'b1;
      if (busy && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rrf_recovery_ctrl.sv
// Directed bench for rrf_recovery_ctrl: per-cycle expected outputs are queued when a
// flush is driven and compared against the DUT on each falling edge.
module tb_rrf_recovery_ctrl;

  localparam int PTAG_W = 6;
  localparam int NARCH  = 32;
  localparam int CW     = 4;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic        wr_en;
    logic [4:0]  base;
    logic [23:0] tag;
    logic        fl;
    logic        done;
  } rec_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    flush_req;
  logic                    regf_we;
  logic [NARCH*PTAG_W-1:0] restore_rat;
  logic                    rename_stall, rat_wr_en, fl_restore, recovery_done, busy;
  logic [4:0]              rat_wr_base;
  logic [CW*PTAG_W-1:0]    rat_wr_tag;
`ifdef RRF_RECOVERY_STATS_EN
  logic [15:0]             flush_count;
  logic [31:0]             stall_cycles;
`endif

  rrf_recovery_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_req     (flush_req),
    .regf_we       (regf_we),
    .restore_rat   (restore_rat),
    .rename_stall  (rename_stall),
    .rat_wr_en     (rat_wr_en),
    .rat_wr_base   (rat_wr_base),
    .rat_wr_tag    (rat_wr_tag),
    .fl_restore    (fl_restore),
    .recovery_done (recovery_done),
    .busy          (busy)
`ifdef RRF_RECOVERY_STATS_EN
    ,
    .flush_count   (flush_count),
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] rr [NARCH];
  rec_t       exp_q [$];
  string      name_q [$];

  localparam rec_t IDLE_REC = '0;

  function automatic rec_t observed();
    rec_t r;
    r.stall = rename_stall;
    r.busy  = busy;
    r.wr_en = rat_wr_en;
    r.base  = rat_wr_base;
    r.tag   = rat_wr_tag;
    r.fl    = fl_restore;
    r.done  = recovery_done;
    return r;
  endfunction

  task automatic check(input rec_t exp, input string nm);
    rec_t obs;
    obs = observed();
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic check_val(input logic [31:0] obs, input logic [31:0] exp, input string nm);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
    end
  endtask

  task automatic apply_rr();
    for (int i = 0; i < NARCH; i++) restore_rat[i*PTAG_W +: PTAG_W] = rr[i];
  endtask

  task automatic push(input rec_t r, input string nm);
    exp_q.push_back(r);
    name_q.push_back(nm);
  endtask

  task automatic push_idle(input string nm);
    push(IDLE_REC, nm);
  endtask

  // Expected stream for one recovery: nwait WAIT cycles, 8 copies, FL_RESET, DONE.
  task automatic push_recovery(input int nwait, input string nm);
    rec_t r;
    for (int w = 0; w < nwait; w++) begin
      r = '0; r.stall = 1'b1; r.busy = 1'b1;
      push(r, $sformatf("%s_wait%0d", nm, w));
    end
    for (int g = 0; g < NARCH / CW; g++) begin
      r = '0; r.stall = 1'b1; r.busy = 1'b1; r.wr_en = 1'b1;
      r.base = 5'(g * CW);
      for (int j = 0; j < CW; j++) r.tag[j*PTAG_W +: PTAG_W] = rr[g*CW + j];
      push(r, $sformatf("%s_copy%0d", nm, g));
    end
    r = '0; r.stall = 1'b1; r.busy = 1'b1; r.fl = 1'b1;
    push(r, {nm, "_fl"});
    r = '0; r.stall = 1'b1; r.busy = 1'b1; r.done = 1'b1;
    push(r, {nm, "_done"});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_underflow observed=empty expected=record");
      end else begin
        check(exp_q.pop_front(), name_q.pop_front());
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush_req = 1'b1;
    regf_we   = 1'b0;
    for (int i = 0; i < NARCH; i++) rr[i] = 6'(i + 32);
    apply_rr();

    // reset dominates a pending flush
    @(negedge clk);
    check(IDLE_REC, "reset_outputs");
    rst_n = 1'b1; flush_req = 1'b0;
    push_idle("post_reset0"); push_idle("post_reset1");
    run(2);

    // basic flush pulse
    flush_req = 1'b1;
    push_recovery(1, "basic"); push_idle("basic_after");
    run(1);
    flush_req = 1'b0;
    run(11);

    // pending commit: regf_we high for the flush edge and two more; entry 5 gets rewritten
    flush_req = 1'b1; regf_we = 1'b1;
    rr[5] = 6'd17;
    push_recovery(3, "pend"); push_idle("pend_after");
    run(1);
    flush_req = 1'b0;
    run(2);
    regf_we = 1'b0;
    apply_rr();
    run(11);

    // flush held through a recovery: absorbed, then restarts from IDLE after DONE
    flush_req = 1'b1;
    push_recovery(1, "rep1"); push_idle("rep_gap");
    push_recovery(1, "rep2"); push_idle("rep_after");
    run(23);
    flush_req = 1'b0;
    run(1);

    // asynchronous reset during COPY group 5
    flush_req = 1'b1;
    push_recovery(1, "mid");
    run(1);
    flush_req = 1'b0;
    run(6);
    exp_q.delete(); name_q.delete();
    #2 rst_n = 1'b0;
    #1 check(IDLE_REC, "midrst_async");
    flush_req = 1'b1;
    push_idle("midrst_hold0"); push_idle("midrst_hold1"); push_idle("midrst_hold2");
    run(3);
    rst_n = 1'b1; flush_req = 1'b0;
    push_idle("midrst_release");
    run(1);

    // full sequence after the aborted one, with illegal regf_we during COPY
    flush_req = 1'b1;
    push_recovery(1, "rerun"); push_idle("rerun_after");
    run(1);
    flush_req = 1'b0;
    run(3);
    regf_we = 1'b1;
    run(4);
    regf_we = 1'b0;
    run(4);

    // two back-to-back recoveries from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    flush_req = 1'b1;
    push_recovery(1, "b2b1"); push_idle("b2b_gap");
    push_recovery(1, "b2b2"); push_idle("b2b_after");
    run(23);
    flush_req = 1'b0;
    run(1);
`ifdef RRF_RECOVERY_STATS_EN
    check_val(32'(flush_count), 32'd2, "flush_count");
    check_val(stall_cycles, 32'd22, "stall_cycles");
`endif

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
